// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared state encoding, error codes and control bit indices for mem_stage
package mem_stage_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_RW       = 2'b11;

  localparam int MEM_BRANCH  = 2;
  localparam int MEM_READ    = 1;
  localparam int MEM_WRITE   = 0;
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  function automatic logic is_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data memory request/ack bus between mem_stage and the memory
interface mem_stage_if #(
  parameter int N = 32
);
  logic         dmem_req;
  logic         dmem_we;
  logic [N-1:0] dmem_addr;
  logic [N-1:0] dmem_wdata;
  logic         dmem_ack;
  logic [N-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_wb_reg.sv
// rtl/mem_wb_reg.sv - MEM/WB pipeline register; load captures a result, bubble clears the writeback control
module mem_wb_reg #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         bubble,
  input  logic         mem_load,
  input  logic [1:0]   wb_in,
  input  logic [N-1:0] alu_in,
  input  logic [4:0]   loadreg_in,
  input  logic [N-1:0] memdata_in,
  output logic [1:0]   wb_out,
  output logic [N-1:0] alu_out,
  output logic [4:0]   loadreg_out,
  output logic [N-1:0] memdata_out
);

  // A bubble only clears the control bits; data fields keep their last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_out      <= 2'b00;
      alu_out     <= '0;
      loadreg_out <= 5'd0;
      memdata_out <= '0;
    end else begin
      if (load) begin
        wb_out      <= wb_in;
        alu_out     <= alu_in;
        loadreg_out <= loadreg_in;
      end else if (bubble) begin
        wb_out <= 2'b00;
      end
      if (load && mem_load) begin
        memdata_out <= memdata_in;
      end
    end
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline MEM stage: issues one data memory access per op, stalls until ack or timeout
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int N       = 32,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   MEM_in,
  input  logic [1:0]   WB_in,
  input  logic [N-1:0] Alu,
  input  logic [N-1:0] Writedata,
  input  logic [4:0]   loadreg,
  mem_stage_if.master  dmem,
  output logic         stall,
  output logic [1:0]   WB_out,
  output logic [N-1:0] Memdata,
  output logic [N-1:0] Alu_wb,
  output logic [4:0]   loadreg_wb,
  output logic         mem_err,
  output logic [1:0]   err_code
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t       state, state_n;
  logic [7:0]   cnt;
  logic [N-1:0] addr_q, wdata_q, alu_q;
  logic         we_q;
  logic [1:0]   wb_q;
  logic [4:0]   lreg_q;

  logic         rd, wr, aligned;
  logic         latch, load, bubble, sel_q, mem_load, err_set;
  logic [1:0]   err_val;
  logic [1:0]   wb_src;
  logic [N-1:0] alu_src;
  logic [4:0]   lreg_src;

  wire unused_branch = MEM_in[MEM_BRANCH];

  assign rd      = MEM_in[MEM_READ];
  assign wr      = MEM_in[MEM_WRITE];
  assign aligned = is_aligned(Alu[1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    stall    = 1'b0;
    latch    = 1'b0;
    load     = 1'b0;
    bubble   = 1'b0;
    sel_q    = 1'b0;
    mem_load = 1'b0;
    err_set  = 1'b0;
    err_val  = ERR_NONE;
    case (state)
      ST_IDLE: begin
        if (rd && wr) begin
          err_set = 1'b1;
          err_val = ERR_RW;
          bubble  = 1'b1;
        end else if (rd || wr) begin
          if (!aligned) begin
            err_set = 1'b1;
            err_val = ERR_MISALIGN;
            bubble  = 1'b1;
          end else begin
            latch   = 1'b1;
            stall   = 1'b1;
            bubble  = 1'b1;
            state_n = ST_BUSY;
          end
        end else begin
          load = 1'b1;
        end
      end
      ST_BUSY: begin
        // An ack in the final counted cycle still completes the access.
        if (dmem.dmem_ack) begin
          load     = 1'b1;
          sel_q    = 1'b1;
          mem_load = !we_q;
          state_n  = ST_IDLE;
        end else begin
          stall  = 1'b1;
          bubble = 1'b1;
          if (cnt == CNT_LAST) begin
            err_set = 1'b1;
            err_val = ERR_TIMEOUT;
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (rst) stall = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (latch) begin
      cnt <= 8'd0;
    end else if (state == ST_BUSY) begin
      cnt <= cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      alu_q   <= '0;
      we_q    <= 1'b0;
      wb_q    <= 2'b00;
      lreg_q  <= 5'd0;
    end else if (latch) begin
      addr_q  <= {Alu[N-1:2], 2'b00};
      wdata_q <= Writedata;
      alu_q   <= Alu;
      we_q    <= wr;
      wb_q    <= WB_in;
      lreg_q  <= loadreg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_err  <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      mem_err <= err_set;
      if (err_set) err_code <= err_val;
    end
  end

  assign dmem.dmem_req   = (state == ST_BUSY);
  assign dmem.dmem_we    = (state == ST_BUSY) && we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;

  assign wb_src   = sel_q ? wb_q   : WB_in;
  assign alu_src  = sel_q ? alu_q  : Alu;
  assign lreg_src = sel_q ? lreg_q : loadreg;

  mem_wb_reg #(.N(N)) u_mem_wb (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .bubble      (bubble),
    .mem_load    (mem_load),
    .wb_in       (wb_src),
    .alu_in      (alu_src),
    .loadreg_in  (lreg_src),
    .memdata_in  (dmem.dmem_rdata),
    .wb_out      (WB_out),
    .alu_out     (Alu_wb),
    .loadreg_out (loadreg_wb),
    .memdata_out (Memdata)
  );

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage with a transaction-level reference model
module tb_mem_stage;
  localparam int N = 32;
  localparam int T = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   MEM_in;
  logic [1:0]   WB_in;
  logic [N-1:0] Alu, Writedata;
  logic [4:0]   loadreg;
  logic         stall, mem_err;
  logic [1:0]   WB_out, err_code;
  logic [N-1:0] Memdata, Alu_wb;
  logic [4:0]   loadreg_wb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_stage_if #(.N(N)) dmem ();

  mem_stage #(.N(N), .TIMEOUT(T)) dut (
    .clk        (clk),
    .rst        (rst),
    .MEM_in     (MEM_in),
    .WB_in      (WB_in),
    .Alu        (Alu),
    .Writedata  (Writedata),
    .loadreg    (loadreg),
    .dmem       (dmem),
    .stall      (stall),
    .WB_out     (WB_out),
    .Memdata    (Memdata),
    .Alu_wb     (Alu_wb),
    .loadreg_wb (loadreg_wb),
    .mem_err    (mem_err),
    .err_code   (err_code)
  );

  typedef struct {
    logic [1:0]   wb;
    logic [N-1:0] memdata;
    logic [1:0]   code;
    bit           commit;
    int           errs;
    int           busy;
    int           stalls;
  } exp_t;

  logic [N-1:0] m_mem;
  logic [1:0]   m_code;

  // Outcome of one instruction; d is the BUSY cycle on which memory acks (d > T: never).
  task automatic model_op(input logic [2:0] mem, input logic [1:0] wb, input logic [N-1:0] alu,
                          input int d, input logic [N-1:0] rdata, output exp_t e);
    bit rd, wr;
    rd = mem[1];
    wr = mem[0];
    e.wb = wb; e.commit = 1; e.errs = 0; e.busy = 0; e.stalls = 0;
    if (rd && wr) begin
      e.wb = 2'b00; e.commit = 0; e.errs = 1; m_code = 2'b11;
    end else if (rd || wr) begin
      if ((alu % 4) != 0) begin
        e.wb = 2'b00; e.commit = 0; e.errs = 1; m_code = 2'b01;
      end else if (d <= T) begin
        e.busy = d; e.stalls = d;
        if (rd) m_mem = rdata;
      end else begin
        e.busy = T; e.stalls = T + 1; e.wb = 2'b00; e.commit = 0; e.errs = 1; m_code = 2'b10;
      end
    end
    e.memdata = m_mem;
    e.code = m_code;
  endtask

  // Presents one instruction at a post-edge instant and plays the memory until the stage is idle again.
  task automatic do_op(input logic [2:0] mem, input logic [1:0] wb, input logic [N-1:0] alu,
                       input logic [N-1:0] wdata, input logic [4:0] lreg, input int d,
                       input logic [N-1:0] rdata, output int busy, output int stalls,
                       output int errs, output int bus_bad, output bit timed_out);
    bit done;
    MEM_in = mem; WB_in = wb; Alu = alu; Writedata = wdata; loadreg = lreg;
    busy = 0; stalls = 0; errs = 0; bus_bad = 0; done = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      if (dmem.dmem_req) begin
        busy++;
        dmem.dmem_ack   = (busy == d);
        dmem.dmem_rdata = (busy == d) ? rdata : N'($urandom);
        if (dmem.dmem_addr !== alu || dmem.dmem_we !== mem[0] || dmem.dmem_wdata !== wdata)
          bus_bad++;
      end else begin
        dmem.dmem_ack   = 1'($urandom_range(0, 1));
        dmem.dmem_rdata = N'($urandom);
      end
      #3;
      if (stall === 1'b1) stalls++;
      @(posedge clk);
      #1;
      if (mem_err === 1'b1) errs++;
      if (dmem.dmem_req !== 1'b1) done = 1;
    end
    timed_out = !done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    MEM_in = 3'b000; WB_in = 2'b00; Alu = '0; Writedata = '0; loadreg = 5'd0;
    dmem.dmem_ack = 1'b0; dmem.dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({dmem.dmem_req, dmem.dmem_we, stall, mem_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got req/we/stall/err=%b%b%b%b, expected 0000",
               dmem.dmem_req, dmem.dmem_we, stall, mem_err);
    end
    checks++;
    if (WB_out !== 2'b00 || Memdata !== '0 || Alu_wb !== '0 || loadreg_wb !== 5'd0 ||
        dmem.dmem_addr !== '0 || dmem.dmem_wdata !== '0 || err_code !== 2'b00) begin
      errors++;
      $display("FAIL reset_data: got wb=%b mem=%h alu=%h lreg=%0d addr=%h wdata=%h code=%b, expected all 0",
               WB_out, Memdata, Alu_wb, loadreg_wb, dmem.dmem_addr, dmem.dmem_wdata, err_code);
    end
    rst = 1'b0;
    m_mem = '0;
    m_code = 2'b00;
  endtask

  task automatic test_noop();
    int b, s, e, bb; bit to; exp_t x;
    model_op(3'b000, 2'b10, 32'h1234, 1, '0, x);
    do_op(3'b000, 2'b10, 32'h1234, 32'h0, 5'd5, 1, '0, b, s, e, bb, to);
    checks++;
    if (WB_out !== 2'b10 || Alu_wb !== 32'h1234 || loadreg_wb !== 5'd5) begin
      errors++;
      $display("FAIL noop_pass: got wb=%b alu=%h lreg=%0d, expected 10 1234 5", WB_out, Alu_wb, loadreg_wb);
    end
    checks++;
    if (s !== 0 || b !== 0 || to) begin
      errors++;
      $display("FAIL noop_stall: got stalls=%0d busy=%0d to=%0d, expected 0 0 0", s, b, to);
    end
  endtask

  task automatic test_load();
    int b, s, e, bb; bit to; exp_t x;
    model_op(3'b010, 2'b11, 32'h100, 3, 32'hDEADBEEF, x);
    do_op(3'b010, 2'b11, 32'h100, 32'h0, 5'd7, 3, 32'hDEADBEEF, b, s, e, bb, to);
    checks++;
    if (b !== 3 || s !== 3 || bb !== 0 || e !== 0 || to) begin
      errors++;
      $display("FAIL load_timing: got req_cycles=%0d stalls=%0d bus_bad=%0d errs=%0d, expected 3 3 0 0", b, s, bb, e);
    end
    checks++;
    if (Memdata !== 32'hDEADBEEF || WB_out !== 2'b11 || loadreg_wb !== 5'd7) begin
      errors++;
      $display("FAIL load_result: got mem=%h wb=%b lreg=%0d, expected deadbeef 11 7", Memdata, WB_out, loadreg_wb);
    end
  endtask

  task automatic test_store();
    int b, s, e, bb; bit to; exp_t x;
    model_op(3'b001, 2'b00, 32'h40, 1, 32'h0BADF00D, x);
    do_op(3'b001, 2'b00, 32'h40, 32'hA5, 5'd0, 1, 32'h0BADF00D, b, s, e, bb, to);
    checks++;
    if (b !== 1 || s !== 1 || bb !== 0 || e !== 0 || to) begin
      errors++;
      $display("FAIL store_timing: got req_cycles=%0d stalls=%0d bus_bad=%0d errs=%0d, expected 1 1 0 0", b, s, bb, e);
    end
    checks++;
    if (Memdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL store_memdata: got %h, expected deadbeef", Memdata);
    end
  endtask

  task automatic test_misaligned();
    int b, s, e, bb; bit to; exp_t x;
    model_op(3'b010, 2'b11, 32'h102, 1, '0, x);
    do_op(3'b010, 2'b11, 32'h102, 32'h0, 5'd3, 1, '0, b, s, e, bb, to);
    checks++;
    if (e !== 1 || err_code !== 2'b01 || b !== 0 || s !== 0 || WB_out !== 2'b00) begin
      errors++;
      $display("FAIL misaligned: got errs=%0d code=%b req_cycles=%0d stalls=%0d wb=%b, expected 1 01 0 0 00",
               e, err_code, b, s, WB_out);
    end
    model_op(3'b000, 2'b01, 32'h8, 1, '0, x);
    do_op(3'b000, 2'b01, 32'h8, 32'h0, 5'd1, 1, '0, b, s, e, bb, to);
    checks++;
    if (e !== 0 || err_code !== 2'b01) begin
      errors++;
      $display("FAIL err_pulse_hold: got errs=%0d code=%b, expected 0 01", e, err_code);
    end
  endtask

  task automatic test_rw_conflict();
    int b, s, e, bb; bit to; exp_t x;
    model_op(3'b011, 2'b11, 32'h200, 1, '0, x);
    do_op(3'b011, 2'b11, 32'h200, 32'h0, 5'd2, 1, '0, b, s, e, bb, to);
    checks++;
    if (e !== 1 || err_code !== 2'b11 || b !== 0 || s !== 0 || WB_out !== 2'b00) begin
      errors++;
      $display("FAIL rw_conflict: got errs=%0d code=%b req_cycles=%0d stalls=%0d wb=%b, expected 1 11 0 0 00",
               e, err_code, b, s, WB_out);
    end
  endtask

  task automatic test_timeout();
    int b, s, e, bb; bit to; exp_t x;
    model_op(3'b010, 2'b11, 32'h300, 100, '0, x);
    do_op(3'b010, 2'b11, 32'h300, 32'h0, 5'd4, 100, '0, b, s, e, bb, to);
    checks++;
    if (b !== 4 || s !== 5 || e !== 1 || err_code !== 2'b10 || WB_out !== 2'b00 || to) begin
      errors++;
      $display("FAIL timeout: got req_cycles=%0d stalls=%0d errs=%0d code=%b wb=%b to=%0d, expected 4 5 1 10 00 0",
               b, s, e, err_code, WB_out, to);
    end
    model_op(3'b010, 2'b11, 32'h304, 4, 32'h13579BDF, x);
    do_op(3'b010, 2'b11, 32'h304, 32'h0, 5'd4, 4, 32'h13579BDF, b, s, e, bb, to);
    checks++;
    if (b !== 4 || e !== 0 || Memdata !== 32'h13579BDF || WB_out !== 2'b11 || err_code !== 2'b10) begin
      errors++;
      $display("FAIL ack_beats_timeout: got req_cycles=%0d errs=%0d mem=%h wb=%b code=%b, expected 4 0 13579bdf 11 10",
               b, e, Memdata, WB_out, err_code);
    end
  endtask

  task automatic test_reset_busy();
    MEM_in = 3'b010; WB_in = 2'b11; Alu = 32'h400; Writedata = 32'h55; loadreg = 5'd9;
    dmem.dmem_ack = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (dmem.dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_busy_setup: got req=%b, expected 1", dmem.dmem_req);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({dmem.dmem_req, dmem.dmem_we, stall, mem_err} !== 4'b0000 || WB_out !== 2'b00 ||
        Memdata !== '0 || dmem.dmem_addr !== '0 || err_code !== 2'b00) begin
      errors++;
      $display("FAIL rst_busy_abandon: got req/we/stall/err=%b%b%b%b wb=%b mem=%h addr=%h code=%b, expected all 0",
               dmem.dmem_req, dmem.dmem_we, stall, mem_err, WB_out, Memdata, dmem.dmem_addr, err_code);
    end
    MEM_in = 3'b000; WB_in = 2'b00;
    @(posedge clk);
    #1;
    rst = 1'b0;
    dmem.dmem_ack = 1'b1;
    dmem.dmem_rdata = 32'hFFFF0000;
    @(posedge clk);
    #1;
    checks++;
    if (mem_err !== 1'b0 || dmem.dmem_req !== 1'b0 || Memdata !== '0) begin
      errors++;
      $display("FAIL rst_late_ack: got err=%b req=%b mem=%h, expected 0 0 0", mem_err, dmem.dmem_req, Memdata);
    end
    dmem.dmem_ack = 1'b0;
    m_mem = '0;
    m_code = 2'b00;
  endtask

  task automatic test_random();
    int b, s, e, bb, d, sel; bit to; exp_t x;
    logic [2:0] mem; logic [1:0] wb; logic [N-1:0] alu, wd, rd; logic [4:0] lr;
    for (int i = 0; i < 150; i++) begin
      sel = int'($urandom_range(0, 9));
      mem = (sel < 3) ? 3'b000 : (sel < 6) ? 3'b010 : (sel < 9) ? 3'b001 : 3'b011;
      if ($urandom_range(0, 1) == 1) mem[2] = 1'b1;
      wb  = 2'($urandom);
      alu = N'($urandom) & ~N'(3);
      if ($urandom_range(0, 5) == 0) alu = alu | N'($urandom_range(1, 3));
      wd  = N'($urandom);
      rd  = N'($urandom);
      lr  = 5'($urandom);
      d   = int'($urandom_range(1, T + 1));
      model_op(mem, wb, alu, d, rd, x);
      do_op(mem, wb, alu, wd, lr, d, rd, b, s, e, bb, to);
      checks++;
      if (to || b !== x.busy || s !== x.stalls || e !== x.errs || bb !== 0) begin
        errors++;
        $display("FAIL rand_timing[%0d]: got busy=%0d stalls=%0d errs=%0d bus_bad=%0d to=%0d, expected %0d %0d %0d 0 0",
                 i, b, s, e, bb, to, x.busy, x.stalls, x.errs);
      end
      checks++;
      if (WB_out !== x.wb || Memdata !== x.memdata || err_code !== x.code) begin
        errors++;
        $display("FAIL rand_result[%0d]: got wb=%b mem=%h code=%b, expected %b %h %b",
                 i, WB_out, Memdata, err_code, x.wb, x.memdata, x.code);
      end
      if (x.commit) begin
        checks++;
        if (Alu_wb !== alu || loadreg_wb !== lr) begin
          errors++;
          $display("FAIL rand_commit[%0d]: got alu=%h lreg=%0d, expected %h %0d", i, Alu_wb, loadreg_wb, alu, lr);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_noop();
    test_load();
    test_store();
    test_misaligned();
    test_rw_conflict();
    test_timeout();
    test_reset_busy();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1);
  end

endmodule
